// File: rtl/mult_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, signed/unsigned
// per operation, valid/ready on both sides, result held under backpressure.
module mult_seq #(
    parameter  int A_W = 2,
    parameter  int B_W = 3,
    localparam int R_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic           signed_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [R_W-1:0] result
);

    localparam int CNT_W = $clog2(B_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(B_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [R_W-1:0]   acc_r;
    logic [R_W-1:0]   amag_r;
    logic [B_W-1:0]   bmag_r;
    logic [CNT_W-1:0] count_r;
    logic             neg_r;
    logic             zero_r;
    logic [R_W-1:0]   result_r;
    logic             out_valid_r;

    logic             accept_s;
    logic             zero_s;
    logic             neg_in_s;
    logic [A_W-1:0]   amag_in_s;
    logic [B_W-1:0]   bmag_in_s;
    logic [R_W-1:0]   acc_next_s;
    logic [R_W-1:0]   prod_s;
    logic             last_s;

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign accept_s  = in_valid && (state_r == IDLE);

    // Operand capture: magnitudes (the most negative value maps onto its unsigned twin) and sign.
    always_comb begin
        amag_in_s = a;
        bmag_in_s = b;
        neg_in_s  = 1'b0;
        zero_s    = (a == {A_W{1'b0}}) || (b == {B_W{1'b0}});
        if (signed_mode && a[A_W-1]) begin
            amag_in_s = (~a) + {{(A_W-1){1'b0}}, 1'b1};
        end else begin
            amag_in_s = a;
        end
        if (signed_mode && b[B_W-1]) begin
            bmag_in_s = (~b) + {{(B_W-1){1'b0}}, 1'b1};
        end else begin
            bmag_in_s = b;
        end
        if (signed_mode) begin
            neg_in_s = a[A_W-1] ^ b[B_W-1];
        end else begin
            neg_in_s = 1'b0;
        end
    end

    // One shift-add iteration and the signed fix-up of the final accumulator.
    always_comb begin
        acc_next_s = acc_r;
        prod_s     = acc_r;
        if (bmag_r[0]) begin
            acc_next_s = acc_r + amag_r;
        end else begin
            acc_next_s = acc_r;
        end
        if (neg_r) begin
            prod_s = (~acc_next_s) + {{(R_W-1){1'b0}}, 1'b1};
        end else begin
            prod_s = acc_next_s;
        end
        // A zero operand finishes after a single pass; the accumulator is already 0.
        last_s = (count_r == LAST_CNT) || zero_r;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, load and hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r       <= {R_W{1'b0}};
            amag_r      <= {R_W{1'b0}};
            bmag_r      <= {B_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            neg_r       <= 1'b0;
            zero_r      <= 1'b0;
            result_r    <= {R_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        acc_r   <= {R_W{1'b0}};
                        amag_r  <= {{B_W{1'b0}}, amag_in_s};
                        bmag_r  <= bmag_in_s;
                        count_r <= {CNT_W{1'b0}};
                        neg_r   <= neg_in_s;
                        zero_r  <= zero_s;
                    end
                end
                CALC: begin
                    acc_r   <= acc_next_s;
                    amag_r  <= amag_r << 1;
                    bmag_r  <= bmag_r >> 1;
                    count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        result_r    <= prod_s;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

endmodule
